// File: rtl/cpu4_ram_ctrl_pkg.sv
// Shared cpu4 definitions: controller FSM state encodings and the data-lane count.
package cpu4_ram_ctrl_pkg;

    localparam int CPU4_DATA_W = 32;
    localparam int CPU4_LANES  = CPU4_DATA_W / 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ISSUE = 3'd1,
        ST_RD_CAPT  = 3'd2,
        ST_WR_ISSUE = 3'd3,
        ST_RESP     = 3'd4
    } cpu4_state_e;

endpackage

// File: rtl/cpu4_ram_ctrl_byte_merge.sv
// cpu4_byte_merge: combinational lane merge for read-modify-write stores.
// Only compiled when CPU4_RAM_CTRL_BYTE_EN is defined.
`ifdef CPU4_RAM_CTRL_BYTE_EN
module cpu4_byte_merge #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   old_word,
    input  logic [DATA_W-1:0]   new_word,
    input  logic [DATA_W/8-1:0] mask,
    output logic [DATA_W-1:0]   merged
);

    always_comb begin
        merged = old_word;
        for (int i = 0; i < DATA_W / 8; i++) begin
            if (mask[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
    end

endmodule
`endif

// File: rtl/cpu4_ram_ctrl.sv
// cpu4 RAM initiator: sequences load/store requests onto a single-port RAM with a
// one-cycle registered read. Byte-masked RMW stores exist only with CPU4_RAM_CTRL_BYTE_EN.
module cpu4_ram_ctrl
    import cpu4_ram_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = CPU4_LANES * 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_bmask,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W-1:0]   ram_data,
    output logic                ram_wren,
    input  logic [DATA_W-1:0]   ram_q,
    output cpu4_state_e         dbg_state
);

    // Handshakes: a request transfers on an edge with req_valid && req_ready, a
    // response on an edge with rsp_valid && rsp_ready; both sides hold until then.
    cpu4_state_e         state_q, state_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_W-1:0]   ram_address_q, ram_address_d;
    logic [DATA_W-1:0]   ram_data_q, ram_data_d;
    logic                ram_wren_q, ram_wren_d;

`ifdef CPU4_RAM_CTRL_BYTE_EN
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] bmask_q, bmask_d;
    logic                pstore_q, pstore_d;
    logic [DATA_W-1:0]   merged;

    cpu4_byte_merge #(.DATA_W(DATA_W)) u_merge (
        .old_word (ram_q),
        .new_word (wdata_q),
        .mask     (bmask_q),
        .merged   (merged)
    );
`else
    logic unused_bmask;
    assign unused_bmask = ^req_bmask;
`endif

    always_comb begin
        state_d       = state_q;
        req_ready_d   = req_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        ram_address_d = ram_address_q;
        ram_data_d    = ram_data_q;
        ram_wren_d    = ram_wren_q;
`ifdef CPU4_RAM_CTRL_BYTE_EN
        wdata_d  = wdata_q;
        bmask_d  = bmask_q;
        pstore_d = pstore_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    if (!req_write) begin
                        ram_address_d = req_addr;
                        ram_wren_d    = 1'b0;
`ifdef CPU4_RAM_CTRL_BYTE_EN
                        pstore_d      = 1'b0;
`endif
                        state_d       = ST_RD_ISSUE;
                    end
`ifdef CPU4_RAM_CTRL_BYTE_EN
                    else if (req_bmask == '0) begin
                        rsp_valid_d = 1'b1;
                        state_d     = ST_RESP;
                    end else if (req_bmask != '1) begin
                        // Partial store: fetch the old word first, merge in RD_CAPT.
                        ram_address_d = req_addr;
                        ram_wren_d    = 1'b0;
                        wdata_d       = req_wdata;
                        bmask_d       = req_bmask;
                        pstore_d      = 1'b1;
                        state_d       = ST_RD_ISSUE;
                    end
`endif
                    else begin
                        ram_address_d = req_addr;
                        ram_data_d    = req_wdata;
                        ram_wren_d    = 1'b1;
                        state_d       = ST_WR_ISSUE;
                    end
                end
            end
            ST_RD_ISSUE: begin
                state_d = ST_RD_CAPT;
            end
            ST_RD_CAPT: begin
`ifdef CPU4_RAM_CTRL_BYTE_EN
                if (pstore_q) begin
                    ram_data_d = merged;
                    ram_wren_d = 1'b1;
                    state_d    = ST_WR_ISSUE;
                end else begin
                    rsp_rdata_d = ram_q;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end
`else
                rsp_rdata_d = ram_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
`endif
            end
            ST_WR_ISSUE: begin
                ram_wren_d  = 1'b0;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                ram_wren_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            ram_address_q <= '0;
            ram_data_q    <= '0;
            ram_wren_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            ram_address_q <= ram_address_d;
            ram_data_q    <= ram_data_d;
            ram_wren_q    <= ram_wren_d;
        end
    end

`ifdef CPU4_RAM_CTRL_BYTE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wdata_q  <= '0;
            bmask_q  <= '0;
            pstore_q <= 1'b0;
        end else begin
            wdata_q  <= wdata_d;
            bmask_q  <= bmask_d;
            pstore_q <= pstore_d;
        end
    end
`endif

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign ram_address = ram_address_q;
    assign ram_data    = ram_data_q;
    assign ram_wren    = ram_wren_q;
    assign dbg_state   = state_q;

endmodule
